lemming_track: RTL
==================

# lemming_track

Position tracker for one lemming, sitting directly downstream of the lemming walker FSM and closing its loop. Consumes the walker's `walk_left`/`walk_right` direction outputs, advances a horizontal position once per step tick, and produces registered `bump_left`/`bump_right` pulses when the lemming reaches a wall. The walker uses these pulses to reverse direction.

## Interface
- `WIDTH`, default 8: position width in bits.
- `X_MAX`, default 200: right wall position. Must be below 2^WIDTH.
- `X_INIT`, default 0: position after reset. Must lie in 0..X_MAX.
- `STEP_DIV`, default 4: clock cycles per step tick. Must be ≥ 1.
- `clk`  in  1  clock.
- `areset`  in  1  asynchronous, active-high reset.
- `enable`  in  1  run the step prescaler. When low, the prescaler and position hold.
- `walk_left`  in  1  walker is heading left.
- `walk_right`  in  1  walker is heading right.
- `bump_left`  out  1  one-cycle pulse: left wall hit.
- `bump_right`  out  1  one-cycle pulse: right wall hit.
- `pos`  out  WIDTH  current position, 0..X_MAX.
- `step`  out  1  one-cycle pulse: a step tick occurred.
- `bump_count`  out  8  total bumps, saturating at 255.
- `dir_err`  out  1  sticky flag: both walk inputs were high on a tick.

## Operation
- **Reset.** Resets are asynchronous, with these values:
  - `pos` = X_INIT
  - prescaler = 0
  - `bump_left`, `bump_right`, `step`, `dir_err` = 0
  - `bump_count` = 0
- **Prescaler.**
  - Counts 0..STEP_DIV-1 while `enable` is high; it holds when `enable` is low.
  - A tick fires in any cycle where `enable` is high and the count equals STEP_DIV-1. The count then wraps to 0.
  - With STEP_DIV=1, a tick fires every enabled cycle.
- **FSM.** States: RUN, AT_LEFT, AT_RIGHT.
  - State is derived from position on every update:
    - AT_LEFT when `pos`==0.
    - AT_RIGHT when `pos`==X_MAX.
    - RUN otherwise.
  - X_INIT selects the reset state.
- **On a tick, by input case:**
  - `walk_left` only, state is not AT_LEFT: `pos` decrements by 1.
  - `walk_left` only, state is AT_LEFT: `pos` holds and `bump_left` pulses.
  - `walk_right` only, state is not AT_RIGHT: `pos` increments by 1.
  - `walk_right` only, state is AT_RIGHT: `pos` holds and `bump_right` pulses.
  - Neither input high: `pos` holds, no bump.
  - Both inputs high: `pos` holds, no bump, and `dir_err` sets. `dir_err` clears only on reset.
- **Bump timing.** A bump fires on the tick after the one that reached the wall, not on the arrival tick. This gives the walker one tick of standing at the wall.
- **Bump counter.** `bump_count` increments on every bump pulse and saturates at 255.
- **Arithmetic.** Position math never wraps. Underflow below 0 and overflow above X_MAX are structurally impossible.

## Timing
- **Tick to output.** For a tick evaluated in cycle t, `pos`, `step`, the bump pulses, `bump_count` and `dir_err` all update at the clk edge ending cycle t. They are visible in cycle t+1.
- **Pulse width.** `step` and bump pulses are high for exactly one cycle.
- **Closed loop with the walker.**
  - The walker samples a bump in cycle t+1 and flips its direction at the end of t+1.
  - The next tick therefore sees the new direction whenever STEP_DIV ≥ 2.
  - With STEP_DIV=1, the tick in t+1 still sees the old direction and produces a second bump pulse. This is the required, documented behaviour.
- **Walk inputs.** Sampled only on tick cycles; they are don't-care otherwise.
- **`enable` falling.** Freezes everything. No pulse is generated in the disabled cycle.
- **Reset mid-operation.** Returns all state to reset values immediately and asynchronously. This includes truncating any bump pulse in flight.

## Structure
- **Shared package `lemmings_pkg`:**
  - enum `track_state_t` {RUN, AT_LEFT, AT_RIGHT}
  - default constants `LEM_POS_W`=8 and `LEM_X_MAX`=200
  - the walker's direction encoding (WL=0, WR=1), shared with the walker
- **Sub-module `step_prescaler`:** parameter STEP_DIV; inputs `clk`, `areset`, `enable`; output `tick`.
- **`lemming_track` itself:** FSM, position register, bump and error logic.

## Test plan
- **Free walk right.** STEP_DIV=4, X_INIT=0, `walk_right` held, `enable`=1 → `pos` increments every 4 cycles; `pos`=3 after 12 cycles; `step` pulses once every 4 cycles.
- **Right wall.** X_INIT=199, `walk_right` held → `pos`=200 after the first tick; the next tick leaves `pos`=200, pulses `bump_right` for 1 cycle, and sets `bump_count`=1.
- **Closed loop with walker.** X_MAX=3, STEP_DIV=2 → `pos` sequence 0,0(bump_left),1,2,3,3(bump_right),2,…; `bump_count` increments on each pulse.
- **Conflict.** Both walk inputs high on a tick at `pos`=5 → `pos` stays 5, no bump, `dir_err`=1 and remains 1 after the inputs clear.
- **Enable gating.** `enable`=0 for 10 cycles mid-count → `pos` and prescaler frozen; counting resumes from the same prescaler value.
- **Async reset.** `areset` asserted for the cycle in which `bump_left` is high → `bump_left`=0 immediately; `pos`=X_INIT and `bump_count`=0 before the next clk edge.

Source files
------------

// File: rtl/lemmings_pkg.sv
`default_nettype none
// ============================================================================
// Module   : lemmings_pkg
// Brief    : Types and constants shared by the lemming walker and tracker.
// Revision : 1.0
// ============================================================================
package lemmings_pkg;

    localparam int LEM_POS_W = 8;
    localparam int LEM_X_MAX = 200;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        AT_LEFT  = 2'd1,
        AT_RIGHT = 2'd2
    } track_state_t;

    // Walker heading; the walker FSM uses the same encoding.
    typedef enum logic {
        WL = 1'b0,
        WR = 1'b1
    } walk_dir_t;

endpackage
`default_nettype wire

// File: rtl/step_prescaler.sv
`default_nettype none
// ============================================================================
// Module   : step_prescaler
// Brief    : Divides the enabled clock down to one step tick every STEP_DIV cycles.
// Revision : 1.0
// ============================================================================
module step_prescaler #(
    parameter int STEP_DIV = 4
) (
    input  logic clk,
    input  logic areset,
    input  logic enable,
    output logic tick
);

    localparam int            CW   = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(STEP_DIV - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // With STEP_DIV=1 the count sits at 0 == LAST, so every enabled cycle ticks.
    assign tick = enable && (cnt_q == LAST);

    always_comb begin
        cnt_d = cnt_q;
        if (enable) begin
            cnt_d = (cnt_q == LAST) ? '0 : cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/lemming_track.sv
`default_nettype none
// ============================================================================
// Module   : lemming_track
// Brief    : Lemming position tracker producing wall-bump pulses for the walker.
// Revision : 1.0
// ============================================================================
module lemming_track
    import lemmings_pkg::*;
#(
    parameter int WIDTH    = LEM_POS_W,
    parameter int X_MAX    = LEM_X_MAX,
    parameter int X_INIT   = 0,
    parameter int STEP_DIV = 4
) (
    input  logic             clk,
    input  logic             areset,
    input  logic             enable,
    input  logic             walk_left,
    input  logic             walk_right,
    output logic             bump_left,
    output logic             bump_right,
    output logic [WIDTH-1:0] pos,
    output logic             step,
    output logic [7:0]       bump_count,
    output logic             dir_err
);

    localparam logic [WIDTH-1:0] X_MAX_V  = WIDTH'(X_MAX);
    localparam logic [WIDTH-1:0] X_INIT_V = WIDTH'(X_INIT);

    function automatic track_state_t state_of(input logic [WIDTH-1:0] p);
        if (p == '0) begin
            return AT_LEFT;
        end else if (p == X_MAX_V) begin
            return AT_RIGHT;
        end
        return RUN;
    endfunction

    logic tick;

    track_state_t     state_q, state_d;
    logic [WIDTH-1:0] pos_q, pos_d;
    logic             bump_left_q, bump_left_d;
    logic             bump_right_q, bump_right_d;
    logic             step_q, step_d;
    logic             dir_err_q, dir_err_d;
    logic [7:0]       bump_count_q, bump_count_d;

    step_prescaler #(
        .STEP_DIV (STEP_DIV)
    ) u_prescaler (
        .clk    (clk),
        .areset (areset),
        .enable (enable),
        .tick   (tick)
    );

    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            state_q      <= state_of(X_INIT_V);
            pos_q        <= X_INIT_V;
            bump_left_q  <= 1'b0;
            bump_right_q <= 1'b0;
            step_q       <= 1'b0;
            dir_err_q    <= 1'b0;
            bump_count_q <= 8'd0;
        end else begin
            state_q      <= state_d;
            pos_q        <= pos_d;
            bump_left_q  <= bump_left_d;
            bump_right_q <= bump_right_d;
            step_q       <= step_d;
            dir_err_q    <= dir_err_d;
            bump_count_q <= bump_count_d;
        end
    end

    // The wall state is only seen on the tick after arrival, which delays the bump by one tick.
    always_comb begin
        pos_d        = pos_q;
        bump_left_d  = 1'b0;
        bump_right_d = 1'b0;
        step_d       = tick;
        dir_err_d    = dir_err_q;
        bump_count_d = bump_count_q;
        if (tick) begin
            unique case ({walk_left, walk_right})
                2'b10: begin
                    if (state_q == AT_LEFT) begin
                        bump_left_d = 1'b1;
                    end else begin
                        pos_d = pos_q - WIDTH'(1);
                    end
                end
                2'b01: begin
                    if (state_q == AT_RIGHT) begin
                        bump_right_d = 1'b1;
                    end else begin
                        pos_d = pos_q + WIDTH'(1);
                    end
                end
                2'b11:   dir_err_d = 1'b1;
                default: ;
            endcase
        end
        if ((bump_left_d || bump_right_d) && (bump_count_q != 8'hFF)) begin
            bump_count_d = bump_count_q + 8'd1;
        end
        state_d = state_of(pos_d);
    end

    always_comb begin
        pos        = pos_q;
        bump_left  = bump_left_q;
        bump_right = bump_right_q;
        step       = step_q;
        dir_err    = dir_err_q;
        bump_count = bump_count_q;
    end

endmodule
`default_nettype wire
